// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single-port main RAM (CPU datapath and debug/loader).
// One access at a time, sequenced IDLE -> ACCESS (RAM_LAT cycles) -> RESP.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              grant_dbg
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [2:0] LatInit = 3'(RAM_LAT);

    state_e     state_q, state_d;
    logic [2:0] lat_cnt_q;
    logic       last_grant_q;  // 1 = debug was granted last
    logic       cur_we_q;
    logic       cpu_elig;
    logic       grant_any;
    logic       pick_dbg;

    always_comb begin
        cpu_elig  = cpu_req & ~dbg_lock;
        grant_any = dbg_req | cpu_elig;
        // Debug wins when the CPU is not eligible, or on a tie when the CPU went last.
        pick_dbg  = dbg_req & (~cpu_elig | ~last_grant_q);

        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_any) state_d = StAccess;
            StAccess: if (lat_cnt_q == 3'd1) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        busy    = (state_q != StIdle);
        cpu_ack = (state_q == StResp) & ~grant_dbg;
        dbg_ack = (state_q == StResp) & grant_dbg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            lat_cnt_q    <= 3'd0;
            last_grant_q <= 1'b1;
            cur_we_q     <= 1'b0;
            grant_dbg    <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_we       <= 1'b0;
            cpu_rdata    <= '0;
            dbg_rdata    <= '0;
        end else begin
            state_q <= state_d;
            ram_we  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        ram_addr     <= pick_dbg ? dbg_addr : cpu_addr;
                        ram_wdata    <= pick_dbg ? dbg_wdata : cpu_wdata;
                        ram_we       <= pick_dbg ? dbg_we : cpu_we;
                        cur_we_q     <= pick_dbg ? dbg_we : cpu_we;
                        grant_dbg    <= pick_dbg;
                        last_grant_q <= pick_dbg;
                        lat_cnt_q    <= LatInit;
                    end
                end
                StAccess: begin
                    lat_cnt_q <= lat_cnt_q - 3'd1;
                    if (lat_cnt_q == 3'd1 && !cur_we_q) begin
                        if (grant_dbg) dbg_rdata <= ram_rdata;
                        else           cpu_rdata <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at RAM_LAT=1 and one at RAM_LAT=3,
// each with a behavioural RAM whose read data appears RAM_LAT cycles after ram_addr.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A, RAM_LAT = 1
    logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
    logic [8:0]  cpu_addr = '0, dbg_addr = '0;
    logic [31:0] cpu_wdata = '0, dbg_wdata = '0;
    logic        cpu_ack, dbg_ack, ram_we, busy, grant_dbg;
    logic [31:0] cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
    logic [8:0]  ram_addr;

    // Instance B, RAM_LAT = 3 (debug side only)
    logic        b_dbg_req = 0;
    logic [8:0]  b_dbg_addr = '0;
    logic        b_cpu_ack, b_dbg_ack, b_ram_we, b_busy, b_grant_dbg;
    logic [31:0] b_cpu_rdata, b_dbg_rdata, b_ram_wdata, b_ram_rdata;
    logic [8:0]  b_ram_addr;

    // Preload path into the RAM models
    logic        pre_we = 0;
    logic [8:0]  pre_addr_a = '0, pre_addr_b = '0;
    logic [31:0] pre_data_a = '0, pre_data_b = '0;

    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];
    logic [31:0] pipe_b1, pipe_b2;

    ram_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_lock(dbg_lock),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .busy(busy), .grant_dbg(grant_dbg)
    );

    ram_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(9'd0), .cpu_wdata(32'd0),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .dbg_req(b_dbg_req), .dbg_we(1'b0), .dbg_addr(b_dbg_addr), .dbg_wdata(32'd0),
        .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata), .dbg_lock(1'b0),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
        .ram_rdata(b_ram_rdata),
        .busy(b_busy), .grant_dbg(b_grant_dbg)
    );

    // Latency 1: data follows the registered address within the same cycle.
    assign ram_rdata = mem_a[ram_addr];
    always @(posedge clk) begin
        if (pre_we)      mem_a[pre_addr_a] <= pre_data_a;
        else if (ram_we) mem_a[ram_addr]   <= ram_wdata;
    end

    // Latency 3: two extra register stages behind the address.
    assign b_ram_rdata = pipe_b2;
    always @(posedge clk) begin
        if (pre_we)        mem_b[pre_addr_b] <= pre_data_b;
        else if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
        pipe_b1 <= mem_b[b_ram_addr];
        pipe_b2 <= pipe_b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    int bad_cnt;

    initial begin
        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_grant_dbg", 32'(grant_dbg), 32'd0);
        pre_we = 1; pre_addr_a = 9'h010; pre_data_a = 32'hDEADBEEF;
        pre_addr_b = 9'h044; pre_data_b = 32'hCAFEF00D;
        tick();
        pre_we = 0;
        tick();
        reset = 0;
        tick();

        // 1: CPU read of 0x010
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_no_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        check("t1_cpu_ack", 32'(cpu_ack), 32'd1);
        check("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t1_dbg_ack", 32'(dbg_ack), 32'd0);
        cpu_req = 0;
        tick();
        check("t1_idle", 32'({busy, cpu_ack}), 32'd0);

        // 2: debug write then CPU read-back
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h1A5; dbg_wdata = 32'h12345678;
        tick();
        check("t2_ram_we", 32'(ram_we), 32'd1);
        check("t2_ram_addr", 32'(ram_addr), 32'h1A5);
        check("t2_ram_wdata", ram_wdata, 32'h12345678);
        check("t2_grant_dbg", 32'(grant_dbg), 32'd1);
        tick();
        check("t2_we_single", 32'(ram_we), 32'd0);
        check("t2_dbg_ack", 32'(dbg_ack), 32'd1);
        dbg_req = 0; dbg_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1A5;
        tick();
        tick();
        check("t2_rd_no_we", 32'(ram_we), 32'd0);
        tick();
        check("t2_cpu_ack", 32'(cpu_ack), 32'd1);
        check("t2_cpu_rdata", cpu_rdata, 32'h12345678);
        check("t2_dbg_rdata_kept", dbg_rdata, 32'd0);
        cpu_req = 0;
        tick();

        // 3: simultaneous requests after reset, round-robin from CPU
        reset = 1;
        tick();
        reset = 0;
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h1A5;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("t3_acks_c%0d", i), 32'({cpu_ack, dbg_ack}),
                  (i == 2 || i == 8) ? 32'd2 : ((i == 5 || i == 11) ? 32'd1 : 32'd0));
            if (i == 11) begin
                cpu_req = 0; dbg_req = 0;
            end
        end
        check("t3_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t3_dbg_rdata", dbg_rdata, 32'h12345678);

        // 4: lock holds the CPU off
        dbg_lock = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h020; cpu_wdata = 32'hA5A5A5A5;
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_ack || ram_we || busy) bad_cnt++;
        end
        check("t4_locked_quiet", 32'(bad_cnt), 32'd0);
        dbg_lock = 0;
        tick();
        check("t4_ram_we", 32'(ram_we), 32'd1);
        tick();
        check("t4_cpu_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 0; cpu_we = 0;

        // 5: reset during the ACCESS cycle of a write
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h030; dbg_wdata = 32'h00000055;
        tick();
        tick();
        check("t5_in_access", 32'({busy, ram_we}), 32'd3);
        reset = 1;
        #1;
        check("t5_ram_we", 32'(ram_we), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
        check("t5_cpu_rdata", cpu_rdata, 32'd0);
        check("t5_dbg_rdata", dbg_rdata, 32'd0);
        dbg_req = 0; dbg_we = 0;
        tick();
        reset = 0;
        bad_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_ack || dbg_ack || busy) bad_cnt++;
        end
        check("t5_no_ack_after", 32'(bad_cnt), 32'd0);

        // 6: RAM_LAT = 3 debug read
        b_dbg_req = 1; b_dbg_addr = 9'h044;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t6_ack_c%0d", i), 32'(b_dbg_ack), (i == 4) ? 32'd1 : 32'd0);
        end
        check("t6_dbg_rdata", b_dbg_rdata, 32'hCAFEF00D);
        check("t6_grant_dbg", 32'(b_grant_dbg), 32'd1);
        b_dbg_req = 0;
        tick();
        check("t6_idle", 32'(b_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
